// File: rtl/display_scan_ctrl.sv
// Scans an 8-nibble display buffer onto a shared seven-segment decoder.
// An optional shadow buffer is committed to the active buffer at frame boundaries.
module display_scan_ctrl #(
   parameter int REFRESH_DIV = 100000,
   parameter bit SYNC_UPDATE = 1'b1,
   parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        wr_en,
   input  logic [2:0]  wr_digit,
   input  logic [3:0]  wr_data,
   input  logic        load_all,
   input  logic [31:0] load_data,
   input  logic [7:0]  blank_mask,
   output logic [3:0]  digit_val,
   output logic [2:0]  digit_sel,
   output logic        digit_blank,
   output logic        scan_tick,
   output logic        frame_done,
   output logic        update_pending
);

   logic [CNT_W-1:0] cnt;
   logic [2:0]       sel;
   logic             tick_q;
   logic             frame_q;
   logic [7:0][3:0]  active;
   logic             last_cnt;
   logic             wrap;
   logic             frame_edge;

   assign last_cnt   = (cnt == CNT_W'(REFRESH_DIV - 1));
   assign wrap       = enable & last_cnt;
   assign frame_edge = wrap & (sel == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         sel     <= 3'd0;
         tick_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         tick_q  <= wrap;
         frame_q <= frame_edge;
         if (enable) begin
            if (last_cnt) begin
               cnt <= '0;
               sel <= sel + 3'd1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   assign digit_sel   = sel;
   assign digit_val   = active[sel];
   assign digit_blank = ~enable | blank_mask[sel];
   assign scan_tick   = tick_q;
   assign frame_done  = frame_q;

   generate
      if (SYNC_UPDATE) begin : g_sync
         logic [7:0][3:0] shadow;
         logic            pending_q;

         // Commit samples the pre-write shadow, so a write on the frame edge waits a frame.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shadow    <= '0;
               active    <= '0;
               pending_q <= 1'b0;
            end else begin
               if (load_all)   shadow           <= load_data;
               else if (wr_en) shadow[wr_digit] <= wr_data;
               if (frame_edge && pending_q) active <= shadow;
               if (load_all || wr_en)       pending_q <= 1'b1;
               else if (frame_edge)         pending_q <= 1'b0;
            end
         end

         assign update_pending = pending_q;
      end else begin : g_direct
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               active <= '0;
            end else begin
               if (load_all)   active           <= load_data;
               else if (wr_en) active[wr_digit] <= wr_data;
            end
         end

         assign update_pending = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: a shadow-buffered and a direct-write
// instance run side by side from the same scan controls.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  blank_mask = 8'h00;

   logic        s_wr_en = 1'b0, d_wr_en = 1'b0;
   logic [2:0]  s_wr_digit = 3'd0, d_wr_digit = 3'd0;
   logic [3:0]  s_wr_data = 4'd0, d_wr_data = 4'd0;
   logic        s_load_all = 1'b0, d_load_all = 1'b0;
   logic [31:0] s_load_data = 32'd0, d_load_data = 32'd0;

   logic [3:0]  s_val, d_val;
   logic [2:0]  s_sel, d_sel;
   logic        s_blank, d_blank, s_tick, d_tick, s_frame, d_frame, s_pend, d_pend;

   int checks = 0;
   int failures = 0;
   int phase = 0;
   logic en_edge = 1'b0;

   always #5 clk = ~clk;

   display_scan_ctrl #(.REFRESH_DIV(4), .SYNC_UPDATE(1'b1)) u_sync (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .wr_en(s_wr_en), .wr_digit(s_wr_digit), .wr_data(s_wr_data),
      .load_all(s_load_all), .load_data(s_load_data), .blank_mask(blank_mask),
      .digit_val(s_val), .digit_sel(s_sel), .digit_blank(s_blank),
      .scan_tick(s_tick), .frame_done(s_frame), .update_pending(s_pend));

   display_scan_ctrl #(.REFRESH_DIV(4), .SYNC_UPDATE(1'b0)) u_dir (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .wr_en(d_wr_en), .wr_digit(d_wr_digit), .wr_data(d_wr_data),
      .load_all(d_load_all), .load_data(d_load_data), .blank_mask(blank_mask),
      .digit_val(d_val), .digit_sel(d_sel), .digit_blank(d_blank),
      .scan_tick(d_tick), .frame_done(d_frame), .update_pending(d_pend));

   // phase counts enabled edges since reset; expected sel/tick/frame derive from it.
   task automatic cyc();
      @(posedge clk);
      en_edge = enable && rst_n;
      if (en_edge) phase++;
      #1;
   endtask

   function automatic logic [2:0] exp_sel();
      return 3'((phase / 4) % 8);
   endfunction

   function automatic logic exp_tick();
      return en_edge && (phase % 4 == 0);
   endfunction

   function automatic logic exp_frame();
      return en_edge && (phase % 32 == 0);
   endfunction

   task automatic goto_sel(input logic [2:0] s);
      for (int i = 0; i < 40 && exp_sel() != s; i++) cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({s_sel, s_val, s_tick, s_frame, s_pend} !== 10'd0) begin
         failures++;
         $display("FAIL reset_sync: got sel=%0d val=%h tick=%b frame=%b pend=%b, want all 0",
                  s_sel, s_val, s_tick, s_frame, s_pend);
      end
      checks++;
      if ({d_sel, d_val, d_tick, d_frame, d_pend, d_blank} !== 11'd1) begin
         failures++;
         $display("FAIL reset_dir: got sel=%0d val=%h tick=%b frame=%b pend=%b blank=%b, want 0s blank=1",
                  d_sel, d_val, d_tick, d_frame, d_pend, d_blank);
      end
      cyc();
      rst_n = 1'b1;
      phase = 0;
      cyc();
   endtask

   task automatic test_scan();
      enable = 1'b1;
      for (int c = 0; c < 33; c++) begin
         cyc();
         checks++;
         if (s_sel !== exp_sel() || s_tick !== exp_tick() || s_frame !== exp_frame()) begin
            failures++;
            $display("FAIL scan_seq phase=%0d: got sel=%0d tick=%b frame=%b, want sel=%0d tick=%b frame=%b",
                     phase, s_sel, s_tick, s_frame, exp_sel(), exp_tick(), exp_frame());
         end
         checks++;
         if (s_val !== 4'd0 || d_val !== 4'd0) begin
            failures++;
            $display("FAIL scan_val phase=%0d: got %h/%h, want 0", phase, s_val, d_val);
         end
      end
   endtask

   task automatic test_direct_load();
      logic [2:0] d;
      d_load_all = 1'b1;
      d_load_data = 32'h7654_3210;
      cyc();
      d_load_all = 1'b0;
      for (int c = 0; c < 32; c++) begin
         checks++;
         if (d_val !== 4'(exp_sel()) || d_sel !== exp_sel()) begin
            failures++;
            $display("FAIL direct_load phase=%0d: got sel=%0d val=%h, want sel=%0d val=%0d",
                     phase, d_sel, d_val, exp_sel(), exp_sel());
         end
         cyc();
      end
      d = 3'(((phase + 1) / 4) % 8);
      d_wr_en = 1'b1;
      d_wr_digit = d;
      d_wr_data = 4'hC;
      cyc();
      d_wr_en = 1'b0;
      checks++;
      if (d_val !== 4'hC || d_pend !== 1'b0) begin
         failures++;
         $display("FAIL direct_write: got val=%h pend=%b, want C 0", d_val, d_pend);
      end
   endtask

   task automatic test_sync_write();
      goto_sel(3'd1);
      s_wr_en = 1'b1;
      s_wr_digit = 3'd3;
      s_wr_data = 4'hA;
      cyc();
      s_wr_en = 1'b0;
      checks++;
      if (s_pend !== 1'b1) begin
         failures++;
         $display("FAIL sync_pending_set: got %b want 1", s_pend);
      end
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (exp_frame()) break;
         if (exp_sel() == 3'd3) begin
            checks++;
            if (s_val !== 4'd0) begin
               failures++;
               $display("FAIL sync_hold phase=%0d: got %h want 0", phase, s_val);
            end
         end
      end
      checks++;
      if (s_frame !== 1'b1 || s_pend !== 1'b0) begin
         failures++;
         $display("FAIL sync_commit: got frame=%b pend=%b, want 1 0", s_frame, s_pend);
      end
      goto_sel(3'd3);
      checks++;
      if (s_val !== 4'hA) begin
         failures++;
         $display("FAIL sync_visible: got %h want A", s_val);
      end
   endtask

   task automatic test_collide();
      s_wr_en = 1'b1;
      s_wr_digit = 3'd2;
      s_wr_data = 4'h5;
      s_load_all = 1'b1;
      s_load_data = 32'hFFFF_FFFF;
      cyc();
      s_wr_en = 1'b0;
      s_load_all = 1'b0;
      for (int i = 0; i < 40 && !exp_frame(); i++) cyc();
      for (int c = 0; c < 32; c++) begin
         if (phase % 4 == 2) begin
            checks++;
            if (s_val !== 4'hF) begin
               failures++;
               $display("FAIL collide sel=%0d: got %h want F", s_sel, s_val);
            end
         end
         cyc();
      end
      // Pending write of digit 1 gets committed on the same edge that a new digit 0 write lands.
      s_wr_en = 1'b1;
      s_wr_digit = 3'd1;
      s_wr_data = 4'h9;
      cyc();
      for (int i = 0; i < 40 && (phase % 32) != 31; i++) begin
         s_wr_en = 1'b0;
         cyc();
      end
      s_wr_en = 1'b1;
      s_wr_digit = 3'd0;
      s_wr_data = 4'h3;
      cyc();
      s_wr_en = 1'b0;
      checks++;
      if (s_frame !== 1'b1 || s_pend !== 1'b1 || s_val !== 4'hF) begin
         failures++;
         $display("FAIL edge_write: got frame=%b pend=%b val=%h, want 1 1 F", s_frame, s_pend, s_val);
      end
      goto_sel(3'd1);
      checks++;
      if (s_val !== 4'h9) begin
         failures++;
         $display("FAIL edge_commit_old: got %h want 9", s_val);
      end
      for (int i = 0; i < 40 && !exp_frame(); i++) cyc();
      checks++;
      if (s_pend !== 1'b0 || s_val !== 4'h3) begin
         failures++;
         $display("FAIL edge_next_frame: got pend=%b val=%h, want 0 3", s_pend, s_val);
      end
   endtask

   task automatic test_blank_enable();
      blank_mask = 8'b1000_0001;
      for (int c = 0; c < 32; c++) begin
         cyc();
         checks++;
         if (s_blank !== (exp_sel() == 3'd0 || exp_sel() == 3'd7)) begin
            failures++;
            $display("FAIL blank_mask sel=%0d: got %b want %b", s_sel, s_blank,
                     (exp_sel() == 3'd0 || exp_sel() == 3'd7));
         end
      end
      goto_sel(3'd4);
      cyc();
      enable = 1'b0;
      #1;
      checks++;
      if (s_blank !== 1'b1 || d_blank !== 1'b1) begin
         failures++;
         $display("FAIL disable_blank_now: got %b/%b want 1", s_blank, d_blank);
      end
      for (int c = 0; c < 10; c++) begin
         cyc();
         checks++;
         if (s_sel !== 3'd4 || s_blank !== 1'b1 || s_tick !== 1'b0 || s_frame !== 1'b0) begin
            failures++;
            $display("FAIL disable_hold: got sel=%0d blank=%b tick=%b frame=%b, want 4 1 0 0",
                     s_sel, s_blank, s_tick, s_frame);
         end
      end
      enable = 1'b1;
      for (int c = 0; c < 8; c++) begin
         cyc();
         checks++;
         if (s_sel !== exp_sel() || s_tick !== exp_tick() || s_blank !== 1'b0) begin
            failures++;
            $display("FAIL resume phase=%0d: got sel=%0d tick=%b blank=%b, want %0d %b 0",
                     phase, s_sel, s_tick, s_blank, exp_sel(), exp_tick());
         end
      end
      blank_mask = 8'h00;
   endtask

   task automatic test_async_reset();
      goto_sel(3'd3);
      s_wr_en = 1'b1;
      s_wr_digit = 3'd5;
      s_wr_data = 4'h7;
      cyc();
      s_wr_en = 1'b0;
      cyc();
      checks++;
      if (s_pend !== 1'b1 || s_sel === 3'd0) begin
         failures++;
         $display("FAIL pre_reset: got pend=%b sel=%0d, want pend 1 sel nonzero", s_pend, s_sel);
      end
      #2 rst_n = 1'b0;
      phase = 0;
      #1;
      checks++;
      if ({s_sel, s_tick, s_frame, s_pend, s_val} !== 10'd0 || d_sel !== 3'd0 || d_val !== 4'd0) begin
         failures++;
         $display("FAIL async_reset: got sel=%0d tick=%b frame=%b pend=%b val=%h dsel=%0d dval=%h, want 0",
                  s_sel, s_tick, s_frame, s_pend, s_val, d_sel, d_val);
      end
      #2 rst_n = 1'b1;
      for (int c = 0; c < 36; c++) begin
         cyc();
         checks++;
         if (s_val !== 4'd0 || s_pend !== 1'b0 || s_sel !== exp_sel()) begin
            failures++;
            $display("FAIL post_reset phase=%0d: got val=%h pend=%b sel=%0d, want 0 0 %0d",
                     phase, s_val, s_pend, s_sel, exp_sel());
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_direct_load();
      test_sync_write();
      test_collide();
      test_blank_enable();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Upstream driver for the 8-digit seven-segment decoder (4-bit value input, 3-bit digit-select input, anodes 0..7).
- Holds an 8-nibble display buffer and time-multiplexes it. At a fixed refresh rate it steps `digit_sel` through 0..7 and presents the matching nibble on `digit_val`.
- Supports per-digit writes, whole-frame loads, per-digit blanking, and optional tear-free frame-synchronous update.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays selected. Legal range is >= 2.
- SYNC_UPDATE, 1:
  - 1: writes go to a shadow buffer and are committed to the active buffer only at a frame boundary.
  - 0: writes go directly to the active buffer.
- CNT_W, $clog2(REFRESH_DIV): refresh counter width. Derived; not overridden.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: scanning enabled. When 0, scan is frozen and the display is blanked.
- wr_en, input, 1: write one digit this cycle.
- wr_digit, input, 3: digit index for wr_en.
- wr_data, input, 4: nibble for wr_en.
- load_all, input, 1: load all 8 digits this cycle.
- load_data, input, 32: digit k = load_data[4k+3:4k].
- blank_mask, input, 8: bit k=1 blanks digit k. Live input, not buffered.
- digit_val, output, 4: nibble for the current digit. Drives decoder value input a.
- digit_sel, output, 3: current digit index. Drives decoder select input b.
- digit_blank, output, 1: 1 means the decoder stage must turn all anodes off.
- scan_tick, output, 1: one-cycle pulse when digit_sel advances.
- frame_done, output, 1: one-cycle pulse when digit_sel wraps 7->0.
- update_pending, output, 1: shadow buffer holds uncommitted writes. Always 0 when SYNC_UPDATE=0.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - active and shadow buffers = 0.
  - refresh counter = 0, digit_sel = 0.
  - scan_tick = 0, frame_done = 0, update_pending = 0.
  - digit_val therefore reads 0.
  - Reset asserted mid-frame or mid-write discards all state; there is no partial commit.
- Refresh counter:
  - When enable=1, it counts 0..REFRESH_DIV-1.
  - On the edge where it sits at REFRESH_DIV-1: counter -> 0, digit_sel -> digit_sel+1 (mod 8), and scan_tick=1 for that following cycle.
  - If digit_sel was 7, it wraps to 0 and frame_done=1 in the same cycle as scan_tick.
  - scan_tick and frame_done are registered outputs.
- enable=0:
  - Counter and digit_sel hold.
  - No ticks.
  - digit_blank is forced to 1.
  - Writes and loads are still accepted.
  - Re-enable resumes from the held count. There is no restart.
- digit_val = active[digit_sel]. Combinational read of registered state.
- digit_blank = ~enable | blank_mask[digit_sel]. Combinational.
- Writes:
  - Write target is shadow when SYNC_UPDATE=1, active when SYNC_UPDATE=0.
  - wr_en: target[wr_digit] <= wr_data.
  - load_all: all 8 target digits <= load_data.
  - If wr_en and load_all are both 1 in the same cycle, load_all wins and wr_en is ignored.
  - With SYNC_UPDATE=0, a write is visible on digit_val the cycle after the write edge.
- Shadow commit (SYNC_UPDATE=1):
  - Any accepted write sets update_pending.
  - On the edge that produces frame_done, if update_pending=1: active <= shadow, and update_pending clears.
  - If a write lands on that same edge:
    - The commit uses the shadow contents before that write.
    - The new write lands in shadow.
    - update_pending stays 1.
  - Shadow is initialised equal to active, both 0 at reset, so an unwritten digit commits its previous value.
  - No commit occurs while enable=0, because there is no frame_done.
- No handshake backpressure: every write is accepted in the cycle it is presented.

Test Plan (REFRESH_DIV=4 unless stated):
- Reset then enable=1, no writes:
  - digit_sel steps 0,1,...,7,0 every 4 cycles.
  - scan_tick pulses every 4th cycle.
  - frame_done pulses once per 32 cycles, coincident with sel 7->0.
  - digit_val=0 throughout.
- SYNC_UPDATE=0, load_all with load_data=32'h7654_3210:
  - digit_val equals digit_sel at every digit (0..7) from the next cycle onward.
- SYNC_UPDATE=1, wr_en digit 3 = 4'hA while digit_sel=1:
  - update_pending=1.
  - digit_val at sel 3 stays 0 for the current frame.
  - After frame_done: update_pending=0 and sel 3 shows 4'hA.
- Same cycle wr_en (digit 2, 4'h5) and load_all (32'hFFFF_FFFF):
  - All digits become F after commit; digit 2 is not 5.
  - Separately, a write on the frame_done edge leaves update_pending=1 and appears only at the following frame.
- blank_mask=8'b1000_0001, and enable dropped to 0 at sel 4 for 10 cycles:
  - digit_blank=1 at sel 0 and sel 7.
  - digit_blank=1 during the whole disable window.
  - digit_sel holds at 4 during disable, then continues with the remaining count.
- Assert rst_n low mid-frame with update_pending=1:
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - The pending shadow data is lost, so digit_val=0 after release.
